// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath mux codes and the bundled control word.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    // Opcodes (Instr[31:26])
    localparam logic [OP_W-1:0] OpR    = 6'b000000;
    localparam logic [OP_W-1:0] OpLw   = 6'b100011;
    localparam logic [OP_W-1:0] OpSw   = 6'b101011;
    localparam logic [OP_W-1:0] OpBeq  = 6'b000100;
    localparam logic [OP_W-1:0] OpBne  = 6'b000101;
    localparam logic [OP_W-1:0] OpAddi = 6'b001000;
    localparam logic [OP_W-1:0] OpAndi = 6'b001100;
    localparam logic [OP_W-1:0] OpOri  = 6'b001101;
    localparam logic [OP_W-1:0] OpJ    = 6'b000010;

    // StReset must stay at zero so a cleared register lands in the quiet state
    typedef enum logic [STATE_W-1:0] {
        StReset  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StIExec  = 4'd9,
        StIWb    = 4'd10,
        StBranch = 4'd11,
        StJump   = 4'd12
    } state_e;

    // ALU operation select
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpLogic = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // PC source select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ior_d;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       zero_extend;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control decode: current state (plus Op, Zero and MemReady where
// a state needs them) to the full datapath control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output ctrl_t           ctrl_o
);

    // Every field defaults to 0 so each state only lists what it asserts
    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StReset: ;
            StFetch: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluOpAdd;
                ctrl_o.pc_src    = PcSrcAlu;
                // Write enables only fire once the fetch completes
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_b  = SrcBImmSh2;
                ctrl_o.alu_op     = AluOpAdd;
                ctrl_o.illegal_op = !(op_i inside {OpR, OpLw, OpSw, OpBeq, OpBne,
                                                   OpAddi, OpAndi, OpOri, OpJ});
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.ior_d   = 1'b1;
            end
            StMemWb: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.ior_d     = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBReg;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            StIExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                // ANDI/ORI take a zero-extended immediate; ADDI is sign-extended
                if (op_i == OpAndi || op_i == OpOri) begin
                    ctrl_o.alu_op      = AluOpLogic;
                    ctrl_o.zero_extend = 1'b1;
                end else begin
                    ctrl_o.alu_op = AluOpAdd;
                end
            end
            StIWb: begin
                ctrl_o.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBReg;
                ctrl_o.alu_op    = AluOpSub;
                ctrl_o.pc_src    = PcSrcAluOut;
                ctrl_o.pc_en     = (op_i == OpBne) ? !zero_i : zero_i;
            end
            StJump: begin
                ctrl_o.pc_src = PcSrcJump;
                ctrl_o.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS core: state register and next-state
// logic here, output decode in mips_ctrl_decode.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            MemReq,
    output logic            MemWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic            ZeroExtend,
    output logic [1:0]      PCSrc,
    output logic            PCEn,
    output logic            IllegalOp
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    // State register; reset overrides any pending transition, including mid-access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; memory states hold until MemReady
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  if (MemReady) state_d = StDecode;
            StDecode: begin
                case (Op)
                    OpLw, OpSw:             state_d = StMemAdr;
                    OpR:                    state_d = StExec;
                    OpAddi, OpAndi, OpOri:  state_d = StIExec;
                    OpBeq, OpBne:           state_d = StBranch;
                    OpJ:                    state_d = StJump;
                    default:                state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (Op == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (MemReady) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (MemReady) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StIExec:  state_d = StIWb;
            StIWb:    state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StReset;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (Op),
        .zero_i      (Zero),
        .mem_ready_i (MemReady),
        .ctrl_o      (ctrl)
    );

    // Flatten the control word onto the datapath-facing ports
    always_comb begin
        MemReq     = ctrl.mem_req;
        MemWrite   = ctrl.mem_write;
        IorD       = ctrl.ior_d;
        IRWrite    = ctrl.ir_write;
        RegWrite   = ctrl.reg_write;
        RegDst     = ctrl.reg_dst;
        MemtoReg   = ctrl.mem_to_reg;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ALUOp      = ctrl.alu_op;
        ZeroExtend = ctrl.zero_extend;
        PCSrc      = ctrl.pc_src;
        PCEn       = ctrl.pc_en;
        IllegalOp  = ctrl.illegal_op;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle control-word checks.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       ZeroExtend, PCEn, IllegalOp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ZeroExtend (ZeroExtend),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .IllegalOp  (IllegalOp)
    );

    // Opcodes
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    // Control word: {MemReq,MemWrite,IorD,IRWrite}_{RegWrite,RegDst,MemtoReg,ALUSrcA}
    //               _ALUSrcB_ALUOp_ZeroExtend_PCSrc_PCEn_IllegalOp
    localparam logic [16:0] S_RST = 17'b0000_0000_00_00_0_00_0_0;
    localparam logic [16:0] S_FW  = 17'b1000_0000_01_00_0_00_0_0;
    localparam logic [16:0] S_FR  = 17'b1001_0000_01_00_0_00_1_0;
    localparam logic [16:0] S_DEC = 17'b0000_0000_11_00_0_00_0_0;
    localparam logic [16:0] S_ILL = 17'b0000_0000_11_00_0_00_0_1;
    localparam logic [16:0] S_MAD = 17'b0000_0001_10_00_0_00_0_0;
    localparam logic [16:0] S_MRD = 17'b1010_0000_00_00_0_00_0_0;
    localparam logic [16:0] S_MWB = 17'b0000_1010_00_00_0_00_0_0;
    localparam logic [16:0] S_MWR = 17'b1110_0000_00_00_0_00_0_0;
    localparam logic [16:0] S_EX  = 17'b0000_0001_00_10_0_00_0_0;
    localparam logic [16:0] S_AWB = 17'b0000_1100_00_00_0_00_0_0;
    localparam logic [16:0] S_IAD = 17'b0000_0001_10_00_0_00_0_0;
    localparam logic [16:0] S_ILG = 17'b0000_0001_10_11_1_00_0_0;
    localparam logic [16:0] S_IWB = 17'b0000_1000_00_00_0_00_0_0;
    localparam logic [16:0] S_BR0 = 17'b0000_0001_00_01_0_01_0_0;
    localparam logic [16:0] S_BR1 = 17'b0000_0001_00_01_0_01_1_0;
    localparam logic [16:0] S_JMP = 17'b0000_0000_00_00_0_10_1_0;

    function automatic logic [16:0] obs();
        return {MemReq, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ALUOp, ZeroExtend, PCSrc, PCEn, IllegalOp};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Op = R; Zero = 1'b0; MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== S_RST) begin
                failures++;
                $display("FAIL reset_held cyc%0d got=%b want=%b", i, obs(), S_RST);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== S_RST) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs(), S_RST);
        end
        tick();
        checks++;
        if (obs() !== S_FW) begin
            failures++;
            $display("FAIL reset_first_fetch got=%b want=%b", obs(), S_FW);
        end
        tick();
    endtask

    task automatic test_ori();
        logic [16:0] exp_q[$];
        exp_q = '{S_FR, S_DEC, S_ILG, S_IWB};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = ORI; MemReady = 1'b1; Zero = 1'b0;
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL ori step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_addi_andi();
        logic [16:0] exp_q[$];
        logic [5:0]  op_q[$];
        exp_q = '{S_FR, S_DEC, S_IAD, S_IWB, S_FR, S_DEC, S_ILG, S_IWB};
        op_q  = '{ADDI, ADDI, ADDI, ADDI, ANDI, ANDI, ANDI, ANDI};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = op_q[i]; MemReady = 1'b1; Zero = 1'b1;
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL addi_andi step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [16:0] exp_q[$];
        logic        rdy_q[$];
        exp_q = '{S_FR, S_DEC, S_MAD, S_MRD, S_MRD, S_MRD, S_MRD, S_MWB};
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = LW; MemReady = rdy_q[i]; Zero = 1'b0;
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL lw_stall step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp_q[$];
        logic [5:0]  op_q[$];
        logic        z_q[$];
        logic        rdy_q[$];
        exp_q = '{S_FR, S_DEC, S_BR1, S_FR, S_DEC, S_BR0,
                  S_FR, S_DEC, S_BR0, S_FR, S_DEC, S_BR1, S_FW};
        op_q  = '{BEQ, BEQ, BEQ, BNE, BNE, BNE, BEQ, BEQ, BEQ, BNE, BNE, BNE, R};
        z_q   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rdy_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = op_q[i]; MemReady = rdy_q[i]; Zero = z_q[i];
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL branch step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q[$];
        logic [5:0]  op_q[$];
        exp_q = '{S_FR, S_DEC, S_EX, S_AWB, S_FR, S_DEC, S_JMP,
                  S_FR, S_DEC, S_MAD, S_MWR, S_FR, S_DEC, S_MAD, S_MRD, S_MWB};
        op_q  = '{R, R, R, R, J, J, J, SW, SW, SW, SW, LW, LW, LW, LW, LW};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = op_q[i]; MemReady = 1'b1; Zero = 1'b0;
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL back_to_back step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [16:0] exp_q[$];
        logic        rdy_q[$];
        exp_q = '{S_FR, S_ILL, S_FW, S_FW};
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = BAD; MemReady = rdy_q[i]; Zero = 1'b0;
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL illegal step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_access();
        logic [16:0] exp_q[$];
        logic        rdy_q[$];
        exp_q = '{S_FR, S_DEC, S_MAD, S_MWR, S_MWR};
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < exp_q.size(); i++) begin
            Op = SW; MemReady = rdy_q[i]; Zero = 1'b0;
            // Assert reset while the store is still waiting for MemReady
            if (i == 4) reset = 1'b1;
            #1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_mid step%0d got=%b want=%b", i, obs(), exp_q[i]);
            end
            tick();
        end
        checks++;
        if (obs() !== S_RST || MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet got=%b want=%b", obs(), S_RST);
        end
        reset = 1'b0;
        MemReady = 1'b1;
        tick();
        checks++;
        if (obs() !== S_FR) begin
            failures++;
            $display("FAIL reset_mid_refetch got=%b want=%b", obs(), S_FR);
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_addi_andi();
        test_lw_stall();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
